// File: rtl/adder_share_sched.sv
// Round-robin scheduler that shares one SLICE-bit adder among NREQ requesters.
// Each WIDTH-bit add is ripple-issued one slice per cycle, LSB first, with a registered carry.
module adder_share_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8,
    parameter int unsigned NREQ  = 2,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IXW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IXW-1:0] LAST_IDX = IXW'(NSLICE - 1);
    localparam logic [IDW-1:0] LAST_REQ = IDW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IXW-1:0]   idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic [31:0]      slice_base;
    logic [SLICE:0]   slice_sum;

    // Search starts one past the last served requester and wraps modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign slice_base = 32'(idx_q) * SLICE;
    assign slice_sum  = {1'b0, a_q[slice_base +: SLICE]} + {1'b0, b_q[slice_base +: SLICE]}
                      + {{SLICE{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        owner_d = owner_q;
        last_d  = last_q;
        id_d    = id_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    a_d     = req_a[32'(gnt_idx) * WIDTH +: WIDTH];
                    b_d     = req_b[32'(gnt_idx) * WIDTH +: WIDTH];
                    owner_d = gnt_idx;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d[slice_base +: SLICE] = slice_sum[SLICE-1:0];
                carry_d = slice_sum[SLICE];
                idx_d   = idx_q + IXW'(1);
                if (idx_q == LAST_IDX) begin
                    // Publish into a separate register so rsp_sum only moves on completion.
                    sum_d   = acc_d;
                    cout_d  = slice_sum[SLICE];
                    id_d    = owner_q;
                    valid_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    last_d  = id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            owner_q <= '0;
            last_q  <= LAST_REQ;
            id_q    <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;

    ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule
